// File: rtl/upg_mem_ctrl_if.sv
// Bus bundle for the UART-programmer memory controller: key input,
// programmer write port, CPU data-memory port, memory write ports,
// reset outputs and status.
interface upg_mem_ctrl_if;
    logic        spg_key;
    logic        upg_wen_i;
    logic        upg_done_i;
    logic [14:0] upg_adr_i;
    logic [31:0] upg_dat_i;
    logic        cpu_dmem_we;
    logic [13:0] cpu_dmem_adr;
    logic [31:0] cpu_dmem_dat;
    logic        imem_we;
    logic [13:0] imem_adr;
    logic [31:0] imem_dat;
    logic        dmem_we;
    logic [13:0] dmem_adr;
    logic [31:0] dmem_dat;
    logic        upg_rst;
    logic        cpu_rst;
    logic        prog_mode;
    logic [14:0] word_cnt;

    // Controller side
    modport slave (
        input  spg_key, upg_wen_i, upg_done_i, upg_adr_i, upg_dat_i,
        input  cpu_dmem_we, cpu_dmem_adr, cpu_dmem_dat,
        output imem_we, imem_adr, imem_dat,
        output dmem_we, dmem_adr, dmem_dat,
        output upg_rst, cpu_rst, prog_mode, word_cnt
    );

    // Environment side (key, programmer, CPU, memories)
    modport master (
        output spg_key, upg_wen_i, upg_done_i, upg_adr_i, upg_dat_i,
        output cpu_dmem_we, cpu_dmem_adr, cpu_dmem_dat,
        input  imem_we, imem_adr, imem_dat,
        input  dmem_we, dmem_adr, dmem_dat,
        input  upg_rst, cpu_rst, prog_mode, word_cnt
    );
endinterface

// File: rtl/upg_mem_ctrl.sv
// UART programmer memory controller. A rising edge of the start key moves
// the CPU into reset and lets the UART programmer write instruction or data
// memory; once the programmer signals done, the CPU is held in reset for
// FLUSH_CYC more cycles before running again.
module upg_mem_ctrl #(
    parameter int FLUSH_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    upg_mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);
    localparam logic [14:0] CNT_MAX   = 15'h7FFF;

    state_t      state_q, state_d;
    logic        key_q;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        wr_pend_q, wr_pend_d;
    logic        wr_tgt_q, wr_tgt_d;
    logic [13:0] wr_adr_q, wr_adr_d;
    logic [31:0] wr_dat_q, wr_dat_d;
    logic [14:0] word_cnt_q, word_cnt_d;
    logic        upg_rst_q, upg_rst_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        prog_mode_q, prog_mode_d;

    // State, write pipeline, counters and registered status outputs.
    // The key register resets to 1 so a key already held down at reset is
    // not seen as a rising edge; reset also drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            key_q       <= 1'b1;
            flush_cnt_q <= 4'd0;
            wr_pend_q   <= 1'b0;
            wr_tgt_q    <= 1'b0;
            wr_adr_q    <= 14'd0;
            wr_dat_q    <= 32'd0;
            word_cnt_q  <= 15'd0;
            upg_rst_q   <= 1'b1;
            cpu_rst_q   <= 1'b1;
            prog_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= bus.spg_key;
            flush_cnt_q <= flush_cnt_d;
            wr_pend_q   <= wr_pend_d;
            wr_tgt_q    <= wr_tgt_d;
            wr_adr_q    <= wr_adr_d;
            wr_dat_q    <= wr_dat_d;
            word_cnt_q  <= word_cnt_d;
            upg_rst_q   <= upg_rst_d;
            cpu_rst_q   <= cpu_rst_d;
            prog_mode_q <= prog_mode_d;
        end
    end

    // Next-state logic: transitions, write capture and word counting.
    // Status outputs are derived from the next state so they change on the
    // same edge as the state itself.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wr_pend_d   = 1'b0;
        wr_tgt_d    = wr_tgt_q;
        wr_adr_d    = wr_adr_q;
        wr_dat_d    = wr_dat_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (bus.spg_key && !key_q) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = 15'd0;
                end
            end
            ST_LOAD: begin
                // A strobe coinciding with done is still captured; it is
                // issued during the first FLUSH cycle.
                if (bus.upg_wen_i) begin
                    wr_pend_d = 1'b1;
                    wr_tgt_d  = bus.upg_adr_i[14];
                    wr_adr_d  = bus.upg_adr_i[13:0];
                    wr_dat_d  = bus.upg_dat_i;
                    if (word_cnt_q != CNT_MAX) begin
                        word_cnt_d = word_cnt_q + 15'd1;
                    end
                end
                if (bus.upg_done_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        upg_rst_d   = (state_d != ST_LOAD);
        cpu_rst_d   = (state_d != ST_RUN);
        prog_mode_d = (state_d != ST_RUN);
    end

    // Memory port steering: programmer pipeline owns both memories outside
    // RUN; in RUN the CPU data port passes straight through.
    always_comb begin
        bus.imem_we  = wr_pend_q && !wr_tgt_q && (state_q != ST_RUN);
        bus.imem_adr = wr_adr_q;
        bus.imem_dat = wr_dat_q;
        bus.dmem_we  = wr_pend_q && wr_tgt_q && (state_q != ST_RUN);
        bus.dmem_adr = wr_adr_q;
        bus.dmem_dat = wr_dat_q;
        if (state_q == ST_RUN) begin
            bus.dmem_we  = bus.cpu_dmem_we;
            bus.dmem_adr = bus.cpu_dmem_adr;
            bus.dmem_dat = bus.cpu_dmem_dat;
        end
    end

    assign bus.upg_rst   = upg_rst_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.prog_mode = prog_mode_q;
    assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_upg_mem_ctrl.sv
// Bench for upg_mem_ctrl: vector tables for CPU pass-through and program
// loads, a write scoreboard checked at every negedge, and hand-written
// sequences for simultaneous write/done, abort and ignored start keys.
module tb_upg_mem_ctrl;

    localparam int FLUSH = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    upg_mem_ctrl_if bus ();

    upg_mem_ctrl #(.FLUSH_CYC(FLUSH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        dmem;
        logic [13:0] adr;
        logic [31:0] dat;
        int          cyc;
    } sb_entry_t;
    sb_entry_t sb[$];

    typedef struct {
        logic [14:0] adr;
        logic [31:0] dat;
        logic        exp_dmem;
        logic [13:0] exp_adr;
    } load_vec_t;

    typedef struct {
        logic        we;
        logic [13:0] adr;
        logic [31:0] dat;
    } pass_vec_t;

    load_vec_t load_tbl[3];
    pass_vec_t pass_tbl[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every programmer write must match the oldest
    // expected write, including the cycle it was due.
    always @(negedge clk) begin
        if (!rst && (bus.imem_we || (bus.dmem_we && bus.prog_mode))) begin
            if (bus.imem_we && bus.dmem_we) begin
                checks++;
                failures++;
                $display("FAIL we_exclusive: imem_we=1 dmem_we=1 required at most one (cycle %0d)", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we: imem_we=%0b dmem_we=%0b with no write due (cycle %0d)",
                         bus.imem_we, bus.dmem_we, cyc);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                check("wr_target", {63'd0, bus.dmem_we}, {63'd0, e.dmem});
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
                if (e.dmem) begin
                    check("wr_dmem_adr", {50'd0, bus.dmem_adr}, {50'd0, e.adr});
                    check("wr_dmem_dat", {32'd0, bus.dmem_dat}, {32'd0, e.dat});
                end else begin
                    check("wr_imem_adr", {50'd0, bus.imem_adr}, {50'd0, e.adr});
                    check("wr_imem_dat", {32'd0, bus.imem_dat}, {32'd0, e.dat});
                end
            end
        end
    end

    task automatic push_write(input logic [14:0] adr, input logic [31:0] dat);
        sb_entry_t e;
        e.dmem = adr[14];
        e.adr  = adr[13:0];
        e.dat  = dat;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        load_tbl[0] = '{15'h0000, 32'h11111111, 1'b0, 14'h0000};
        load_tbl[1] = '{15'h0001, 32'h22222222, 1'b0, 14'h0001};
        load_tbl[2] = '{15'h4002, 32'hDEADBEEF, 1'b1, 14'h0002};

        pass_tbl[0] = '{1'b1, 14'h0123, 32'hA5A5A5A5};
        pass_tbl[1] = '{1'b0, 14'h3FFF, 32'h0000FFFF};
        pass_tbl[2] = '{1'b1, 14'h2000, 32'h12345678};

        rst = 1'b1;
        bus.spg_key = 1'b0;
        bus.upg_wen_i = 1'b0;
        bus.upg_done_i = 1'b0;
        bus.upg_adr_i = '0;
        bus.upg_dat_i = '0;
        bus.cpu_dmem_we = 1'b0;
        bus.cpu_dmem_adr = '0;
        bus.cpu_dmem_dat = '0;

        // Reset then idle
        repeat (3) tick();
        check("rst_upg_rst", {63'd0, bus.upg_rst}, 64'd1);
        check("rst_cpu_rst", {63'd0, bus.cpu_rst}, 64'd1);
        check("rst_prog_mode", {63'd0, bus.prog_mode}, 64'd0);
        check("rst_word_cnt", {49'd0, bus.word_cnt}, 64'd0);
        check("rst_imem_we", {63'd0, bus.imem_we}, 64'd0);
        rst = 1'b0;
        tick();
        check("idle_cpu_rst", {63'd0, bus.cpu_rst}, 64'd0);
        check("idle_upg_rst", {63'd0, bus.upg_rst}, 64'd1);
        check("idle_prog_mode", {63'd0, bus.prog_mode}, 64'd0);
        check("idle_word_cnt", {49'd0, bus.word_cnt}, 64'd0);

        // CPU pass-through in RUN, same cycle
        for (int i = 0; i < 3; i++) begin
            bus.cpu_dmem_we  = pass_tbl[i].we;
            bus.cpu_dmem_adr = pass_tbl[i].adr;
            bus.cpu_dmem_dat = pass_tbl[i].dat;
            #1;
            check("pass_dmem_we", {63'd0, bus.dmem_we}, {63'd0, pass_tbl[i].we});
            check("pass_dmem_adr", {50'd0, bus.dmem_adr}, {50'd0, pass_tbl[i].adr});
            check("pass_dmem_dat", {32'd0, bus.dmem_dat}, {32'd0, pass_tbl[i].dat});
            check("pass_imem_we", {63'd0, bus.imem_we}, 64'd0);
            tick();
        end

        // CPU keeps writing throughout the load; it must be blocked
        bus.cpu_dmem_we  = 1'b1;
        bus.cpu_dmem_adr = 14'h3ABC;
        bus.cpu_dmem_dat = 32'hBADBADBA;

        // Three-word load, back-to-back strobes, key toggled mid-load
        bus.spg_key = 1'b1;
        tick();
        bus.spg_key = 1'b0;
        check("load_prog_mode", {63'd0, bus.prog_mode}, 64'd1);
        check("load_cpu_rst", {63'd0, bus.cpu_rst}, 64'd1);
        check("load_upg_rst", {63'd0, bus.upg_rst}, 64'd0);
        check("load_word_cnt", {49'd0, bus.word_cnt}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            bus.upg_wen_i = 1'b1;
            bus.upg_adr_i = load_tbl[i].adr;
            bus.upg_dat_i = load_tbl[i].dat;
            bus.spg_key   = (i == 1);
            begin
                sb_entry_t e;
                e.dmem = load_tbl[i].exp_dmem;
                e.adr  = load_tbl[i].exp_adr;
                e.dat  = load_tbl[i].dat;
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            tick();
        end
        bus.upg_wen_i = 1'b0;
        bus.spg_key = 1'b0;
        tick();
        bus.upg_done_i = 1'b1;
        tick();
        bus.upg_done_i = 1'b0;
        check("flush_word_cnt", {49'd0, bus.word_cnt}, 64'd3);
        check("flush_prog_mode", {63'd0, bus.prog_mode}, 64'd1);
        check("flush_upg_rst", {63'd0, bus.upg_rst}, 64'd1);

        // Measure the CPU reset hold while toggling the key in FLUSH
        n = 0;
        while (bus.cpu_rst && n < 20) begin
            bus.spg_key = (n != 1);
            n++;
            tick();
        end
        bus.spg_key = 1'b0;
        check("flush_len", 64'(n), 64'(FLUSH));
        tick();
        tick();
        check("post_prog_mode", {63'd0, bus.prog_mode}, 64'd0);
        check("post_word_cnt", {49'd0, bus.word_cnt}, 64'd3);
        check("post_cpu_rst", {63'd0, bus.cpu_rst}, 64'd0);

        // Simultaneous last write and done
        bus.spg_key = 1'b1;
        tick();
        bus.spg_key = 1'b0;
        check("sim_word_cnt_clr", {49'd0, bus.word_cnt}, 64'd0);
        bus.upg_wen_i  = 1'b1;
        bus.upg_done_i = 1'b1;
        bus.upg_adr_i  = 15'h0005;
        bus.upg_dat_i  = 32'hCAFEF00D;
        push_write(15'h0005, 32'hCAFEF00D);
        tick();
        bus.upg_wen_i  = 1'b0;
        bus.upg_done_i = 1'b0;
        check("sim_word_cnt", {49'd0, bus.word_cnt}, 64'd1);
        check("sim_upg_rst", {63'd0, bus.upg_rst}, 64'd1);
        n = 0;
        while (bus.prog_mode && n < 20) begin
            n++;
            tick();
        end
        check("sim_flush_len", 64'(n), 64'(FLUSH));

        // Abort: reset arrives while a second write is in the pipeline
        bus.cpu_dmem_we = 1'b0;
        bus.spg_key = 1'b1;
        tick();
        bus.spg_key = 1'b0;
        bus.upg_wen_i = 1'b1;
        bus.upg_adr_i = 15'h0010;
        bus.upg_dat_i = 32'h0BADF00D;
        push_write(15'h0010, 32'h0BADF00D);
        tick();
        bus.upg_adr_i = 15'h4011;
        bus.upg_dat_i = 32'h55AA55AA;
        tick();
        rst = 1'b1;
        bus.upg_wen_i = 1'b0;
        #1;
        check("abort_imem_we", {63'd0, bus.imem_we}, 64'd0);
        check("abort_dmem_we", {63'd0, bus.dmem_we}, 64'd0);
        check("abort_word_cnt", {49'd0, bus.word_cnt}, 64'd0);
        check("abort_prog_mode", {63'd0, bus.prog_mode}, 64'd0);
        check("abort_cpu_rst", {63'd0, bus.cpu_rst}, 64'd1);
        tick();
        tick();
        rst = 1'b0;
        bus.upg_wen_i = 1'b1;
        repeat (3) tick();
        bus.upg_wen_i = 1'b0;
        check("abort_run_prog", {63'd0, bus.prog_mode}, 64'd0);
        check("abort_run_cnt", {49'd0, bus.word_cnt}, 64'd0);
        check("abort_run_cpu_rst", {63'd0, bus.cpu_rst}, 64'd0);

        // Key held high through reset must not start a load
        bus.spg_key = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("keyrst_prog_mode", {63'd0, bus.prog_mode}, 64'd0);
        check("keyrst_cpu_rst", {63'd0, bus.cpu_rst}, 64'd0);
        bus.spg_key = 1'b0;
        tick();
        check("keyrst_prog_mode2", {63'd0, bus.prog_mode}, 64'd0);

        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
